// File: rtl/vrf_arb_pkg.sv
// vrf_arbiter shared types.
// Write and read FSM state encodings.
package vrf_arb_pkg;

   typedef enum logic {
      WR_IDLE,
      WR_ACK
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_WAIT,
      RD_GNT
   } rd_state_t;

endpackage

// File: rtl/vrf_arbiter.sv
// MA-unit VRF arbiter: port A serves source reads,
// port B serves result writes, on a dual-port BRAM.
module vrf_arbiter
   import vrf_arb_pkg::*;
#(
   parameter int VRF_ADDR_WIDTH = 10,
   parameter int VRF_DATA_WIDTH = 1024,
   parameter int READ_DELAY     = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic [VRF_ADDR_WIDTH-1:0] bram_a_addr_o,
   input  logic [VRF_DATA_WIDTH-1:0] bram_a_dout_i,
   output logic [VRF_DATA_WIDTH-1:0] bram_a_din_o,
   output logic                      bram_a_en_o,
   output logic                      bram_a_we_o,
   output logic [VRF_ADDR_WIDTH-1:0] bram_b_addr_o,
   input  logic [VRF_DATA_WIDTH-1:0] bram_b_dout_i,
   output logic [VRF_DATA_WIDTH-1:0] bram_b_din_o,
   output logic                      bram_b_en_o,
   output logic                      bram_b_we_o,
   input  logic [VRF_ADDR_WIDTH-1:0] ma_v_src_addr_i,
   output logic [VRF_DATA_WIDTH-1:0] ma_v_src_data_o,
   input  logic                      ma_read_req_i,
   output logic                      ma_read_gnt_o,
   input  logic [VRF_ADDR_WIDTH-1:0] ma_v_res_addr_i,
   input  logic [VRF_DATA_WIDTH-1:0] ma_v_res_data_i,
   input  logic                      ma_write_req_i,
   output logic                      ma_write_gnt_o
);

   localparam int CW = $clog2(READ_DELAY + 2);

   wr_state_t wr_q, wr_d;
   rd_state_t rd_q, rd_d;

   logic [CW-1:0] cnt_q, cnt_d;

   logic                      wr_fire_d;
   logic [VRF_ADDR_WIDTH-1:0] b_addr_d;
   logic [VRF_DATA_WIDTH-1:0] b_din_d;

   logic                      a_en_d;
   logic                      rgnt_d;
   logic [VRF_ADDR_WIDTH-1:0] a_addr_d;
   logic [VRF_DATA_WIDTH-1:0] src_d;

   logic wr_issue;
   logic hazard;
   logic rd_issue;
   logic unused_dout_b;

   assign bram_a_din_o  = '0;
   assign bram_a_we_o   = 1'b0;
   assign unused_dout_b = ^bram_b_dout_i;

   // Same-address read slips a cycle so it sees the new word.
   assign wr_issue = (wr_q == WR_IDLE) && ma_write_req_i;
   assign hazard   = wr_issue &&
                     (ma_v_res_addr_i == ma_v_src_addr_i);
   assign rd_issue = (rd_q == RD_IDLE) && ma_read_req_i
                     && !hazard;

   always_comb begin
      wr_d      = wr_q;
      wr_fire_d = 1'b0;
      b_addr_d  = bram_b_addr_o;
      b_din_d   = bram_b_din_o;
      unique case (wr_q)
         WR_IDLE: begin
            if (wr_issue) begin
               wr_d      = WR_ACK;
               wr_fire_d = 1'b1;
               b_addr_d  = ma_v_res_addr_i;
               b_din_d   = ma_v_res_data_i;
            end
         end
         WR_ACK: wr_d = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      a_en_d   = 1'b0;
      rgnt_d   = 1'b0;
      a_addr_d = bram_a_addr_o;
      src_d    = ma_v_src_data_o;
      unique case (rd_q)
         RD_IDLE: begin
            if (rd_issue) begin
               rd_d     = RD_WAIT;
               a_en_d   = 1'b1;
               a_addr_d = ma_v_src_addr_i;
               cnt_d    = '0;
            end
         end
         RD_WAIT: begin
            if (cnt_q == CW'(READ_DELAY)) begin
               rd_d   = RD_GNT;
               rgnt_d = 1'b1;
               src_d  = bram_a_dout_i;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RD_GNT:  rd_d = RD_IDLE;
         default: rd_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q            <= WR_IDLE;
         rd_q            <= RD_IDLE;
         cnt_q           <= '0;
         bram_b_en_o     <= 1'b0;
         bram_b_we_o     <= 1'b0;
         ma_write_gnt_o  <= 1'b0;
         bram_b_addr_o   <= '0;
         bram_b_din_o    <= '0;
         bram_a_en_o     <= 1'b0;
         bram_a_addr_o   <= '0;
         ma_read_gnt_o   <= 1'b0;
         ma_v_src_data_o <= '0;
      end else begin
         wr_q            <= wr_d;
         rd_q            <= rd_d;
         cnt_q           <= cnt_d;
         bram_b_en_o     <= wr_fire_d;
         bram_b_we_o     <= wr_fire_d;
         ma_write_gnt_o  <= wr_fire_d;
         bram_b_addr_o   <= b_addr_d;
         bram_b_din_o    <= b_din_d;
         bram_a_en_o     <= a_en_d;
         bram_a_addr_o   <= a_addr_d;
         ma_read_gnt_o   <= rgnt_d;
         ma_v_src_data_o <= src_d;
      end
   end

endmodule

// File: tb/tb_vrf_arbiter.sv
// Bench for vrf_arbiter with a behavioural dual-port
// BRAM and a word-level VRF model.
module tb_vrf_arbiter;

   localparam int AW = 10;
   localparam int DW = 64;
   localparam int RD = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] bram_a_addr_o;
   logic [DW-1:0] bram_a_dout_i;
   logic [DW-1:0] bram_a_din_o;
   logic          bram_a_en_o;
   logic          bram_a_we_o;
   logic [AW-1:0] bram_b_addr_o;
   logic [DW-1:0] bram_b_dout_i;
   logic [DW-1:0] bram_b_din_o;
   logic          bram_b_en_o;
   logic          bram_b_we_o;
   logic [AW-1:0] ma_v_src_addr_i = '0;
   logic [DW-1:0] ma_v_src_data_o;
   logic          ma_read_req_i = 1'b0;
   logic          ma_read_gnt_o;
   logic [AW-1:0] ma_v_res_addr_i = '0;
   logic [DW-1:0] ma_v_res_data_i = '0;
   logic          ma_write_req_i = 1'b0;
   logic          ma_write_gnt_o;

   int n_chk  = 0;
   int n_fail = 0;

   logic          tb_clear = 1'b1;
   logic [DW-1:0] mem [1<<AW];
   logic [DW-1:0] pipe [RD];
   logic [DW-1:0] ref_mem [1<<AW];

   always #5 clk = ~clk;

   vrf_arbiter #(
      .VRF_ADDR_WIDTH(AW),
      .VRF_DATA_WIDTH(DW),
      .READ_DELAY    (RD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bram_a_addr_o  (bram_a_addr_o),
      .bram_a_dout_i  (bram_a_dout_i),
      .bram_a_din_o   (bram_a_din_o),
      .bram_a_en_o    (bram_a_en_o),
      .bram_a_we_o    (bram_a_we_o),
      .bram_b_addr_o  (bram_b_addr_o),
      .bram_b_dout_i  (bram_b_dout_i),
      .bram_b_din_o   (bram_b_din_o),
      .bram_b_en_o    (bram_b_en_o),
      .bram_b_we_o    (bram_b_we_o),
      .ma_v_src_addr_i(ma_v_src_addr_i),
      .ma_v_src_data_o(ma_v_src_data_o),
      .ma_read_req_i  (ma_read_req_i),
      .ma_read_gnt_o  (ma_read_gnt_o),
      .ma_v_res_addr_i(ma_v_res_addr_i),
      .ma_v_res_data_i(ma_v_res_data_i),
      .ma_write_req_i (ma_write_req_i),
      .ma_write_gnt_o (ma_write_gnt_o)
   );

   // Dual-port BRAM: RD-cycle read pipeline, write on port B.
   always @(posedge clk) begin
      if (tb_clear) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      end else if (bram_b_en_o && bram_b_we_o) begin
         mem[bram_b_addr_o] <= bram_b_din_o;
      end
      if (bram_a_en_o) pipe[0] <= mem[bram_a_addr_o];
      for (int i = 1; i < RD; i++) pipe[i] <= pipe[i-1];
   end

   assign bram_a_dout_i = pipe[RD-1];
   assign bram_b_dout_i = '1;

   task automatic chk(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " a_en"}, 64'(bram_a_en_o), 64'd0);
      chk({tag, " b_en"}, 64'(bram_b_en_o), 64'd0);
      chk({tag, " b_we"}, 64'(bram_b_we_o), 64'd0);
      chk({tag, " rgnt"}, 64'(ma_read_gnt_o), 64'd0);
      chk({tag, " wgnt"}, 64'(ma_write_gnt_o), 64'd0);
      chk({tag, " src"}, ma_v_src_data_o, 64'd0);
      chk({tag, " b_din"}, bram_b_din_o, 64'd0);
      chk({tag, " b_addr"}, 64'(bram_b_addr_o), 64'd0);
      chk({tag, " a_addr"}, 64'(bram_a_addr_o), 64'd0);
   endtask

   // One read and/or write; expectations from the VRF model.
   task automatic xfer(input string tag,
                       input bit do_rd, input logic [AW-1:0] ra,
                       input bit do_wr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
      int rlat = 0;
      int wlat = 0;
      int aen  = 0;
      int rg   = 0;
      int wg   = 0;
      logic [DW-1:0] rdat = '0;
      bit same;
      int exp_rlat;
      logic [DW-1:0] exp_rd;
      same     = do_wr && (wa == ra);
      exp_rlat = same ? RD + 3 : RD + 2;
      exp_rd   = same ? wd : ref_mem[ra];
      ma_v_src_addr_i = ra;
      ma_v_res_addr_i = wa;
      ma_v_res_data_i = wd;
      ma_read_req_i   = do_rd;
      ma_write_req_i  = do_wr;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (bram_a_en_o && aen == 0) aen = c;
         if (ma_write_gnt_o) begin
            wg++;
            if (wlat == 0) begin
               wlat = c;
               chk({tag, " b_addr"}, 64'(bram_b_addr_o),
                   64'(wa));
               chk({tag, " b_din"}, bram_b_din_o, wd);
               chk({tag, " b_we"}, 64'(bram_b_we_o), 64'd1);
            end
            ma_write_req_i = 1'b0;
         end
         if (ma_read_gnt_o) begin
            rg++;
            if (rlat == 0) begin
               rlat = c;
               rdat = ma_v_src_data_o;
            end
            ma_read_req_i = 1'b0;
         end
      end
      ma_read_req_i  = 1'b0;
      ma_write_req_i = 1'b0;
      if (do_wr) begin
         ref_mem[wa] = wd;
         chk({tag, " wlat"}, 64'(wlat), 64'd1);
         chk({tag, " wcnt"}, 64'(wg), 64'd1);
         chk({tag, " mem"}, mem[wa], wd);
      end
      if (do_rd) begin
         chk({tag, " aen"}, 64'(aen), 64'(exp_rlat - RD - 1));
         chk({tag, " rlat"}, 64'(rlat), 64'(exp_rlat));
         chk({tag, " rcnt"}, 64'(rg), 64'd1);
         chk({tag, " rdata"}, rdat, exp_rd);
         chk({tag, " hold"}, ma_v_src_data_o, exp_rd);
         chk({tag, " a_we"}, 64'(bram_a_we_o), 64'd0);
         chk({tag, " a_din"}, bram_a_din_o, 64'd0);
      end
   endtask

   initial begin
      int gc [4];
      int n;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

      #3;
      chk_idle("rst");
      #19;
      rst_n    = 1'b1;
      tb_clear = 1'b0;
      step();
      chk_idle("post_rst");

      // Single write, req held through WR_ACK
      ma_v_res_addr_i = 10'd2;
      ma_v_res_data_i = 64'd5;
      ma_write_req_i  = 1'b1;
      step();
      chk("w1 gnt", 64'(ma_write_gnt_o), 64'd1);
      chk("w1 en", 64'(bram_b_en_o), 64'd1);
      chk("w1 we", 64'(bram_b_we_o), 64'd1);
      chk("w1 addr", 64'(bram_b_addr_o), 64'd2);
      chk("w1 din", bram_b_din_o, 64'd5);
      step();
      chk("w1 ack gnt", 64'(ma_write_gnt_o), 64'd0);
      chk("w1 ack we", 64'(bram_b_we_o), 64'd0);
      ma_write_req_i = 1'b0;
      step();
      chk("w1 no2nd", 64'(ma_write_gnt_o), 64'd0);
      step();
      chk("w1 mem", mem[2], 64'd5);
      ref_mem[2] = 64'd5;

      xfer("rd2", 1'b1, 10'd2, 1'b0, 10'd0, 64'd0);

      // Burst of four writes with req held high
      n = 0;
      ma_v_res_addr_i = 10'd2;
      ma_v_res_data_i = 64'd5;
      ma_write_req_i  = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (ma_write_gnt_o && n < 4) begin
            gc[n] = c;
            n++;
            if (n < 4) begin
               ma_v_res_addr_i = AW'(2 + n);
               ma_v_res_data_i = 64'(5 + n);
            end else begin
               ma_write_req_i = 1'b0;
            end
         end
      end
      ma_write_req_i = 1'b0;
      chk("burst n", 64'(n), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("burst gnt", 64'(gc[i]), 64'(2 * i + 1));
         chk("burst mem", mem[2 + i], 64'(5 + i));
         ref_mem[2 + i] = 64'(5 + i);
      end

      // Same-address hazard, then disjoint addresses
      xfer("pre7", 1'b0, 10'd0, 1'b1, 10'd7, 64'd1);
      xfer("haz7", 1'b1, 10'd7, 1'b1, 10'd7, 64'd9);
      xfer("rd3wr4", 1'b1, 10'd3, 1'b1, 10'd4, 64'h44);

      // Reset while the read is in RD_WAIT
      ma_v_src_addr_i = 10'd2;
      ma_read_req_i   = 1'b1;
      step();
      ma_read_req_i   = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("abort");
      for (int i = 0; i < 4; i++) begin
         step();
         chk("abort gnt", 64'(ma_read_gnt_o), 64'd0);
      end
      #3;
      rst_n = 1'b1;
      step();
      chk("abort after", 64'(ma_read_gnt_o), 64'd0);
      xfer("rd_after", 1'b1, 10'd3, 1'b0, 10'd0, 64'd0);

      // Random mix over a small address window
      for (int t = 0; t < 24; t++) begin
         int op;
         logic [AW-1:0] ra, wa;
         logic [DW-1:0] wd;
         op = $urandom_range(0, 2);
         ra = AW'($urandom_range(0, 7));
         wa = ($urandom_range(0, 1) == 1) ? ra :
              AW'($urandom_range(0, 7));
         wd = {$urandom, $urandom};
         xfer("rand", op != 0, ra, op != 1, wa, wd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
